// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard: tracks in-flight register producers behind decode
// and resolves each decode read as stage-forward, register-file fallback, or stall.
module fwd_scoreboard #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int STAGES = 3,
    parameter int NREAD  = 2,
    parameter int SCW    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_dst,
    input  logic [1:0]            iss_lat,
    input  logic [STAGES*DW-1:0]  stg_data,
    input  logic [NREAD*AW-1:0]   rd_addr,
    input  logic [NREAD*DW-1:0]   rf_data,
    output logic [NREAD*DW-1:0]   fwd_data,
    output logic [NREAD-1:0]      fwd_hit,
    output logic                  stall,
    output logic [SCW-1:0]        stall_cnt
);

    // Result latency can never exceed the oldest tracked stage, nor the 2-bit counter.
    localparam logic [1:0] LAT_MAX = (STAGES - 1 >= 3) ? 2'd3 : 2'(STAGES - 1);

    logic           v_q   [STAGES];
    logic           v_d   [STAGES];
    logic [AW-1:0]  dst_q [STAGES];
    logic [AW-1:0]  dst_d [STAGES];
    logic [1:0]     cnt_q [STAGES];
    logic [1:0]     cnt_d [STAGES];
    logic [SCW-1:0] stall_cnt_q;
    logic [SCW-1:0] stall_cnt_d;

    logic [NREAD*DW-1:0] fwd_data_s;
    logic [NREAD-1:0]    fwd_hit_s;
    logic [NREAD-1:0]    pend_s;
    logic                stall_s;
    logic [1:0]          lat_clamp_s;

    // Per-port lookup: only the youngest matching entry counts, ready or not.
    always_comb begin : lookup_p
        logic found;
        found      = 1'b0;
        fwd_data_s = rf_data;
        fwd_hit_s  = '0;
        pend_s     = '0;
        for (int p = 0; p < NREAD; p++) begin
            found = 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                if (!found && v_q[k] && (dst_q[k] == rd_addr[p*AW +: AW]) &&
                    (rd_addr[p*AW +: AW] != '0)) begin
                    found = 1'b1;
                    if (cnt_q[k] == 2'd0) begin
                        fwd_hit_s[p]             = 1'b1;
                        fwd_data_s[p*DW +: DW]   = stg_data[k*DW +: DW];
                    end else begin
                        pend_s[p] = 1'b1;
                    end
                end else begin
                    found = found;
                end
            end
        end
        stall_s = |pend_s;
    end

    // Next-state: flush clears validity, otherwise advance shifts entries when enabled.
    always_comb begin
        lat_clamp_s = (iss_lat > LAT_MAX) ? LAT_MAX : iss_lat;
        v_d         = v_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                v_d[k] = 1'b0;
            end
        end else if (en) begin
            for (int k = 1; k < STAGES; k++) begin
                v_d[k]   = v_q[k-1];
                dst_d[k] = dst_q[k-1];
                cnt_d[k] = (cnt_q[k-1] == 2'd0) ? 2'd0 : cnt_q[k-1] - 2'd1;
            end
            // A stalled issue enters as a bubble; r0 writes are never tracked.
            if (stall_s || !iss_valid || (iss_dst == '0)) begin
                v_d[0]   = 1'b0;
                dst_d[0] = '0;
                cnt_d[0] = 2'd0;
            end else begin
                v_d[0]   = 1'b1;
                dst_d[0] = iss_dst;
                cnt_d[0] = lat_clamp_s;
            end
            if (stall_s && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + SCW'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                dst_q[k] <= '0;
                cnt_q[k] <= 2'd0;
            end
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_data  = fwd_data_s;
    assign fwd_hit   = fwd_hit_s;
    assign stall     = stall_s;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vector table, hand-written flush/freeze
// sequences, then random traffic against an age-based in-flight model.
module tb_fwd_scoreboard;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int ST  = 3;
    localparam int NR  = 2;
    localparam int SCW = 16;

    localparam logic [31:0] RF0 = 32'hF0F0_0000;
    localparam logic [31:0] RF1 = 32'hF1F1_0001;

    logic              clk;
    logic              reset;
    logic              en;
    logic              flush;
    logic              iss_valid;
    logic [AW-1:0]     iss_dst;
    logic [1:0]        iss_lat;
    logic [ST*DW-1:0]  stg_data;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rf_data;
    logic [NR*DW-1:0]  fwd_data;
    logic [NR-1:0]     fwd_hit;
    logic              stall;
    logic [SCW-1:0]    stall_cnt;

    int vectors = 0;
    int errors  = 0;

    fwd_scoreboard #(.DW(DW), .AW(AW), .STAGES(ST), .NREAD(NR), .SCW(SCW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .iss_lat   (iss_lat),
        .stg_data  (stg_data),
        .rd_addr   (rd_addr),
        .rf_data   (rf_data),
        .fwd_data  (fwd_data),
        .fwd_hit   (fwd_hit),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stage k holds the instruction issued k advances ago;
    // its result is ready once its age has reached its latency.
    typedef struct {
        bit            v;
        logic [AW-1:0] dst;
        int            lat;
    } ment_t;

    ment_t          mq[$];
    logic [SCW-1:0] mcnt;

    function automatic void model_clear();
        mq.delete();
        for (int k = 0; k < ST; k++) mq.push_back('{1'b0, 5'd0, 0});
        mcnt = 16'd0;
    endfunction

    function automatic void model_eval(output logic [1:0] h, output logic s,
                                       output logic [63:0] d);
        logic [AW-1:0] a;
        bit found;
        h = 2'b00;
        s = 1'b0;
        d = rf_data;
        for (int p = 0; p < NR; p++) begin
            a = rd_addr[p*AW +: AW];
            found = 1'b0;
            for (int k = 0; k < ST; k++) begin
                if (!found && mq[k].v && mq[k].dst == a && a != 5'd0) begin
                    found = 1'b1;
                    if (k >= mq[k].lat) begin
                        h[p] = 1'b1;
                        d[p*DW +: DW] = stg_data[k*DW +: DW];
                    end else begin
                        s = 1'b1;
                    end
                end
            end
        end
    endfunction

    function automatic void model_step();
        logic [1:0]  h;
        logic        s;
        logic [63:0] d;
        ment_t       e;
        model_eval(h, s, d);
        if (reset) begin
            model_clear();
        end else if (flush) begin
            for (int k = 0; k < ST; k++) mq[k].v = 1'b0;
        end else if (en) begin
            e.v   = iss_valid && !s && (iss_dst != 5'd0);
            e.dst = iss_dst;
            e.lat = (int'(iss_lat) > ST - 1) ? ST - 1 : int'(iss_lat);
            mq.push_front(e);
            void'(mq.pop_back());
            if (s && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] eh, input logic es,
                       input logic [15:0] ec, input logic [31:0] e0, input logic [31:0] e1);
        vectors++;
        if (fwd_hit !== eh || stall !== es || stall_cnt !== ec || fwd_data !== {e1, e0}) begin
            errors++;
            $display("FAIL %s: hit=%b stall=%b cnt=%0d data=%h/%h, want hit=%b stall=%b cnt=%0d data=%h/%h",
                     name, fwd_hit, stall, stall_cnt, fwd_data[31:0], fwd_data[63:32],
                     eh, es, ec, e0, e1);
        end
    endtask

    task automatic drive(input logic e, input logic f, input logic iv, input logic [4:0] dst,
                         input logic [1:0] lat, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
        en        = e;
        flush     = f;
        iss_valid = iv;
        iss_dst   = dst;
        iss_lat   = lat;
        rd_addr   = {r1, r0};
        stg_data  = {s2, s1, s0};
    endtask

    typedef struct {
        logic        en, fl, iv;
        logic [4:0]  dst;
        logic [1:0]  lat;
        logic [4:0]  r0, r1;
        logic [31:0] s0, s1, s2;
        logic [1:0]  eh;
        logic        es;
        logic [15:0] ec;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [1:0]  mh;
        logic        ms;
        logic [63:0] md;

        // ALU forward, load-use, youngest priority, r0, latency clamp
        tbl[0]  = '{1'b1,1'b0,1'b1, 5'd5, 2'd0, 5'd0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b0,16'd0, RF0,       RF1};
        tbl[1]  = '{1'b1,1'b0,1'b0, 5'd0, 2'd0, 5'd5, 5'd0, 32'h1234, 32'h0,    32'h0,    2'b01,1'b0,16'd0, 32'h1234,  RF1};
        tbl[2]  = '{1'b1,1'b0,1'b0, 5'd0, 2'd0, 5'd5, 5'd0, 32'hDEAD, 32'h1234, 32'h0,    2'b01,1'b0,16'd0, 32'h1234,  RF1};
        tbl[3]  = '{1'b1,1'b0,1'b1, 5'd8, 2'd2, 5'd0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b0,16'd0, RF0,       RF1};
        tbl[4]  = '{1'b1,1'b0,1'b0, 5'd0, 2'd0, 5'd0, 5'd8, 32'h0,    32'h0,    32'h0,    2'b00,1'b1,16'd0, RF0,       RF1};
        tbl[5]  = '{1'b1,1'b0,1'b0, 5'd0, 2'd0, 5'd0, 5'd8, 32'h0,    32'h0,    32'h0,    2'b00,1'b1,16'd1, RF0,       RF1};
        tbl[6]  = '{1'b1,1'b0,1'b0, 5'd0, 2'd0, 5'd0, 5'd8, 32'h0,    32'h0,    32'h8888, 2'b10,1'b0,16'd2, RF0,       32'h8888};
        tbl[7]  = '{1'b1,1'b0,1'b1, 5'd3, 2'd0, 5'd0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b0,16'd2, RF0,       RF1};
        tbl[8]  = '{1'b1,1'b0,1'b1, 5'd9, 2'd0, 5'd0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b0,16'd2, RF0,       RF1};
        tbl[9]  = '{1'b1,1'b0,1'b1, 5'd3, 2'd0, 5'd0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b0,16'd2, RF0,       RF1};
        tbl[10] = '{1'b0,1'b0,1'b0, 5'd0, 2'd0, 5'd3, 5'd3, 32'hBBBB, 32'h0,    32'hAAAA, 2'b11,1'b0,16'd2, 32'hBBBB,  32'hBBBB};
        tbl[11] = '{1'b1,1'b0,1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b0,16'd2, RF0,       RF1};
        tbl[12] = '{1'b1,1'b0,1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b0,16'd2, RF0,       RF1};
        tbl[13] = '{1'b0,1'b0,1'b0, 5'd0, 2'd0, 5'd3, 5'd0, 32'hBBBB, 32'h0,    32'hAAAA, 2'b00,1'b1,16'd2, RF0,       RF1};
        tbl[14] = '{1'b1,1'b0,1'b1, 5'd0, 2'd0, 5'd0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b0,16'd2, RF0,       RF1};
        tbl[15] = '{1'b1,1'b0,1'b0, 5'd0, 2'd0, 5'd0, 5'd3, 32'h7777, 32'h3333, 32'h0,    2'b10,1'b0,16'd2, RF0,       32'h3333};
        tbl[16] = '{1'b1,1'b0,1'b1, 5'd12,2'd3, 5'd0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b0,16'd2, RF0,       RF1};
        tbl[17] = '{1'b1,1'b0,1'b0, 5'd0, 2'd0, 5'd12,5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b1,16'd2, RF0,       RF1};
        tbl[18] = '{1'b1,1'b0,1'b0, 5'd0, 2'd0, 5'd12,5'd0, 32'h0,    32'h0,    32'h0,    2'b00,1'b1,16'd3, RF0,       RF1};
        tbl[19] = '{1'b1,1'b0,1'b0, 5'd0, 2'd0, 5'd12,5'd0, 32'h0,    32'h0,    32'hC0C0, 2'b01,1'b0,16'd4, 32'hC0C0,  RF1};

        // Reset with random inputs
        model_clear();
        reset     = 1'b1;
        en        = 1'($urandom_range(1));
        flush     = 1'($urandom_range(1));
        iss_valid = 1'($urandom_range(1));
        iss_dst   = 5'($urandom_range(31));
        iss_lat   = 2'($urandom_range(3));
        stg_data  = {$urandom, $urandom, $urandom};
        rd_addr   = {5'($urandom_range(31)), 5'($urandom_range(31))};
        rf_data   = {$urandom, $urandom};
        @(posedge clk);
        #1;
        rd_addr   = {5'($urandom_range(31)), 5'($urandom_range(31))};
        rf_data   = {$urandom, $urandom};
        iss_valid = 1'b1;
        @(negedge clk);
        chk("reset", 2'b00, 1'b0, 16'd0, rf_data[31:0], rf_data[63:32]);
        tick();
        reset   = 1'b0;
        rf_data = {RF1, RF0};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].dst, tbl[i].lat,
                  tbl[i].r0, tbl[i].r1, tbl[i].s0, tbl[i].s1, tbl[i].s2);
            @(negedge clk);
            chk($sformatf("tbl%0d", i), tbl[i].eh, tbl[i].es, tbl[i].ec, tbl[i].e0, tbl[i].e1);
            tick();
        end

        // Flush with a pending load and a concurrent issue
        drive(1'b1,1'b0,1'b1,5'd7,2'd2,5'd0,5'd0,32'h0,32'h0,32'h0);
        @(negedge clk); chk("fl_issue", 2'b00, 1'b0, 16'd4, RF0, RF1); tick();
        drive(1'b1,1'b1,1'b1,5'd10,2'd0,5'd7,5'd0,32'h0,32'h0,32'h0);
        @(negedge clk); chk("fl_pend", 2'b00, 1'b1, 16'd4, RF0, RF1); tick();
        drive(1'b0,1'b0,1'b0,5'd0,2'd0,5'd7,5'd10,32'h0,32'h0,32'h0);
        @(negedge clk); chk("fl_after", 2'b00, 1'b0, 16'd4, RF0, RF1); tick();

        // Freeze: en low holds entries and the stall counter
        drive(1'b1,1'b0,1'b1,5'd7,2'd2,5'd0,5'd0,32'h0,32'h0,32'h0);
        @(negedge clk); chk("fz_issue", 2'b00, 1'b0, 16'd4, RF0, RF1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0,1'b0,1'b0,5'd0,2'd0,5'd7,5'd0,32'h0,32'h0,32'h0);
            @(negedge clk); chk($sformatf("fz_hold%0d", i), 2'b00, 1'b1, 16'd4, RF0, RF1); tick();
        end
        drive(1'b1,1'b0,1'b0,5'd0,2'd0,5'd7,5'd0,32'h0,32'h0,32'h0);
        @(negedge clk); chk("fz_adv1", 2'b00, 1'b1, 16'd4, RF0, RF1); tick();
        drive(1'b0,1'b0,1'b0,5'd0,2'd0,5'd7,5'd0,32'h0,32'h0,32'h0);
        @(negedge clk); chk("fz_hold_s1", 2'b00, 1'b1, 16'd5, RF0, RF1); tick();
        drive(1'b1,1'b0,1'b0,5'd0,2'd0,5'd7,5'd0,32'h0,32'h0,32'h0);
        @(negedge clk); chk("fz_adv2", 2'b00, 1'b1, 16'd5, RF0, RF1); tick();
        drive(1'b1,1'b0,1'b0,5'd0,2'd0,5'd7,5'd0,32'h0,32'h0,32'h7070);
        @(negedge clk); chk("fz_ready", 2'b01, 1'b0, 16'd6, 32'h7070, RF1); tick();

        // Random traffic against the model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(199) == 0);
            en        = ($urandom_range(9) != 0);
            flush     = ($urandom_range(19) == 0);
            iss_valid = 1'($urandom_range(1));
            iss_dst   = 5'($urandom_range(7));
            iss_lat   = 2'($urandom_range(3));
            stg_data  = {$urandom, $urandom, $urandom};
            rd_addr   = {5'($urandom_range(7)), 5'($urandom_range(7))};
            rf_data   = {$urandom, $urandom};
            @(negedge clk);
            model_eval(mh, ms, md);
            chk("rand", mh, ms, mcnt, md[31:0], md[63:32]);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
